// File: rtl/arm_defs.sv
// Shared ARM encoding definitions: instruction mode codes, ALU command
// codes as produced by the ID-stage decode, data-processing opcodes, and
// the decoded control bundle carried into the encoder.
package arm_defs;

    // Instruction class field [27:26]
    localparam logic [1:0] MODE_DP  = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;

    // ALU command codes driven by the decode unit
    localparam logic [3:0] ALU_MOV = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_ADC = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_SBC = 4'b0101;
    localparam logic [3:0] ALU_AND = 4'b0110;
    localparam logic [3:0] ALU_ORR = 4'b0111;
    localparam logic [3:0] ALU_EOR = 4'b1000;
    localparam logic [3:0] ALU_MVN = 4'b1001;

    // Data-processing opcode field [24:21]
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    // Decoded control bundle plus register/immediate fields
    typedef struct packed {
        logic [3:0]  alu_command;
        logic        mem_read;
        logic        mem_write;
        logic        wb_en;
        logic        branch;
        logic        status_en;
        logic [3:0]  cond;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic        imm;
        logic [11:0] shift_operand;
        logic [23:0] imm24;
    } bundle_t;

endpackage

// File: rtl/instr_encode.sv
// Combinational re-encoder: decoded control bundle -> 32-bit ARM word,
// plus a flag for bundles the decode unit could never have produced.
module instr_encode
    import arm_defs::*;
(
    input  bundle_t     bundle,
    output logic [31:0] word,
    output logic        illegal
);

    logic [3:0] opcode;
    logic       opcode_ok;
    logic       cmp_tst;
    logic [1:0] n_kind;

    // Map ALU command to opcode and build the word, branch > mem > data-proc
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case/if chain can leave a signal unassigned (latch).
        word      = '0;
        illegal   = 1'b0;
        opcode    = OP_AND;
        opcode_ok = 1'b1;
        cmp_tst   = 1'b0;
        n_kind    = {1'b0, bundle.branch} + {1'b0, bundle.mem_read} + {1'b0, bundle.mem_write};

        case (bundle.alu_command)
            ALU_MOV: opcode = OP_MOV;
            ALU_MVN: opcode = OP_MVN;
            ALU_ADD: opcode = OP_ADD;
            ALU_ADC: opcode = OP_ADC;
            ALU_SBC: opcode = OP_SBC;
            ALU_ORR: opcode = OP_ORR;
            ALU_EOR: opcode = OP_EOR;
            ALU_SUB: begin
                opcode  = bundle.wb_en ? OP_SUB : OP_CMP;
                cmp_tst = !bundle.wb_en;
            end
            ALU_AND: begin
                opcode  = bundle.wb_en ? OP_AND : OP_TST;
                cmp_tst = !bundle.wb_en;
            end
            default: opcode_ok = 1'b0;
        endcase

        if (n_kind > 2'd1) begin
            illegal = 1'b1;
        end else if (bundle.branch) begin
            // The ALU command is a don't-care for branches
            word    = {bundle.cond, MODE_BR, 1'b1, 1'b0, bundle.imm24};
            illegal = bundle.mem_read | bundle.mem_write | bundle.wb_en | bundle.status_en;
        end else if (bundle.mem_read || bundle.mem_write) begin
            // Pre-indexed, add offset, word access, no writeback
            word    = {bundle.cond, MODE_MEM, 1'b0, 4'b1100, bundle.mem_read,
                       bundle.rn, bundle.rd, bundle.shift_operand};
            illegal = (bundle.alu_command != ALU_ADD)
                    | (bundle.mem_write & bundle.wb_en)
                    | (bundle.mem_read & !bundle.wb_en);
        end else begin
            word    = {bundle.cond, MODE_DP, bundle.imm, opcode, bundle.status_en,
                       bundle.rn, bundle.rd, bundle.shift_operand};
            illegal = !opcode_ok
                    | (!bundle.wb_en & !bundle.status_en)
                    | (cmp_tst & !bundle.status_en);
        end
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts decoded bundles, re-encodes them and writes the
// words sequentially into the instruction-memory write port until full.
module instr_encoder_loader
    import arm_defs::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu_command,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              wb_en,
    input  logic              branch,
    input  logic              status_en,
    input  logic [3:0]        cond,
    input  logic [3:0]        rn,
    input  logic [3:0]        rd,
    input  logic              imm,
    input  logic [11:0]       shift_operand,
    input  logic [23:0]       imm24,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ack,
    output logic              full,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENCODE,
        S_WRITE,
        S_FULL
    } state_t;

    state_t          state, state_next;
    bundle_t         bundle_q;
    logic [31:0]     enc_word;
    logic            enc_illegal;
    logic [ADDR_W:0] count_inc;
    logic            accept;

    assign accept    = (state == S_IDLE) && in_valid && in_ready;
    assign count_inc = word_count + (ADDR_W + 1)'(1);
    assign imem_we   = (state == S_WRITE);
    assign full      = (state == S_FULL);

    instr_encode u_encode (
        .bundle  (bundle_q),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (accept) state_next = S_ENCODE;
            S_ENCODE: state_next = enc_illegal ? S_IDLE : S_WRITE;
            S_WRITE:  if (imem_ack) state_next = (count_inc == DEPTH_CNT) ? S_FULL : S_IDLE;
            S_FULL:   if (restart) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Bundle capture, encoded word, address/count, sticky error, ready
    always_ff @(posedge clk) begin
        if (!rst) begin
            bundle_q   <= '0;
            imem_wdata <= '0;
            imem_addr  <= BASE;
            word_count <= '0;
            err        <= 1'b0;
            in_ready   <= 1'b0;
        end else begin
            // Registered so it stays low during the reset cycle itself
            in_ready <= (state_next == S_IDLE);

            // A write in flight always completes; restart is ignored then
            if (restart && state != S_WRITE) begin
                imem_addr  <= BASE;
                word_count <= '0;
                err        <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        bundle_q <= '{alu_command: alu_command, mem_read: mem_read,
                                      mem_write: mem_write, wb_en: wb_en, branch: branch,
                                      status_en: status_en, cond: cond, rn: rn, rd: rd,
                                      imm: imm, shift_operand: shift_operand, imm24: imm24};
                    end
                end
                S_ENCODE: begin
                    if (enc_illegal) err        <= 1'b1;
                    else             imem_wdata <= enc_word;
                end
                S_WRITE: begin
                    if (imem_ack) begin
                        imem_addr  <= imem_addr + ADDR_W'(1);
                        word_count <= count_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed ARM encodings, illegal bundles,
// ack back-pressure, fill-to-full, restart, reset mid-write, and random
// bundles checked against an arithmetic encoding model.
module tb_instr_encoder_loader;

    localparam int ADDR_W    = 8;
    localparam int DEPTH     = 4;
    localparam int BASE_ADDR = 0;

    // Opcode by ALU command (-1 = unmapped); SUB/AND entries are the
    // writeback forms, CMP/TST substituted when wb_en is 0.
    localparam int OP_TAB [16] = '{-1, 13, 4, 5, 2, 6, 0, 12, 1, 15, -1, -1, -1, -1, -1, -1};

    typedef struct {
        logic [3:0]  alu;
        logic        mem_read, mem_write, wb_en, branch, status_en;
        logic [3:0]  cond, rn, rd;
        logic        imm;
        logic [11:0] shift;
        logic [23:0] imm24;
    } bun_t;

    logic              clk = 1'b0;
    logic              rst, restart, in_valid, in_ready;
    logic [3:0]        alu_command, cond, rn, rd;
    logic              mem_read, mem_write, wb_en, branch, status_en, imm;
    logic [11:0]       shift_operand;
    logic [23:0]       imm24;
    logic              imem_we, imem_ack, full, err;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   word_count;

    int n_vec = 0;
    int n_bad = 0;

    // Reference state
    int  exp_count;
    int  exp_addr;
    bit  exp_err;
    bit  exp_full;

    always #5 clk = ~clk;

    instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
        .clk(clk), .rst(rst), .restart(restart), .in_valid(in_valid), .in_ready(in_ready),
        .alu_command(alu_command), .mem_read(mem_read), .mem_write(mem_write), .wb_en(wb_en),
        .branch(branch), .status_en(status_en), .cond(cond), .rn(rn), .rd(rd), .imm(imm),
        .shift_operand(shift_operand), .imm24(imm24), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .imem_ack(imem_ack), .full(full), .err(err),
        .word_count(word_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic bit ref_legal(input bun_t b);
        int kinds = int'(b.branch) + int'(b.mem_read) + int'(b.mem_write);
        bit cmp_tst = !b.wb_en && (b.alu == 4'd4 || b.alu == 4'd6);
        if (kinds > 1) return 1'b0;
        if (b.branch) return !(b.mem_read || b.mem_write || b.wb_en || b.status_en);
        if (b.mem_read || b.mem_write)
            return b.alu == 4'd2 && !(b.mem_write && b.wb_en) && !(b.mem_read && !b.wb_en);
        if (OP_TAB[b.alu] < 0) return 1'b0;
        if (!b.wb_en && !b.status_en) return 1'b0;
        if (cmp_tst && !b.status_en) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] ref_word(input bun_t b);
        int unsigned w = int'(b.cond) << 28;
        int opc = OP_TAB[b.alu];
        if (b.branch) return w | (32'hA << 24) | int'(b.imm24);
        w = w | (int'(b.rn) << 16) | (int'(b.rd) << 12) | int'(b.shift);
        if (b.mem_read || b.mem_write) return w | ((32'h58 | int'(b.mem_read)) << 20);
        if (!b.wb_en && b.alu == 4'd4) opc = 10;
        if (!b.wb_en && b.alu == 4'd6) opc = 8;
        return w | (int'(b.imm) << 25) | (opc << 21) | (int'(b.status_en) << 20);
    endfunction

    function automatic bun_t blank();
        bun_t b;
        b = '{alu: 4'd0, mem_read: 1'b0, mem_write: 1'b0, wb_en: 1'b0, branch: 1'b0,
              status_en: 1'b0, cond: 4'hE, rn: 4'd0, rd: 4'd0, imm: 1'b0, shift: 12'd0,
              imm24: 24'd0};
        return b;
    endfunction

    task automatic drive(input bun_t b);
        alu_command = b.alu;   mem_read = b.mem_read; mem_write = b.mem_write;
        wb_en = b.wb_en;       branch = b.branch;     status_en = b.status_en;
        cond = b.cond;         rn = b.rn;             rd = b.rd;
        imm = b.imm;           shift_operand = b.shift; imm24 = b.imm24;
    endtask

    // Offer one bundle, follow it through encode/write with ack_delay idle
    // ack cycles, and check outcome against the model. Inputs change on negedges.
    task automatic send(input bun_t b, input int ack_delay, output logic [31:0] got);
        bit legal = ref_legal(b);
        logic [31:0] w = ref_word(b);
        int waited = 0;
        bit saw_we = 1'b0;
        got = 'x;
        while (!in_ready && waited < 8) begin @(negedge clk); waited++; end
        check("in_ready before send", 32'(in_ready), 32'd1);
        drive(b);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("in_ready after accept", 32'(in_ready), 32'd0);
        if (legal) begin
            waited = 0;
            while (!imem_we && waited < 6) begin @(negedge clk); waited++; end
            check("imem_we latency", 32'(waited), 32'd1);
            check("imem_addr", 32'(imem_addr), 32'(exp_addr));
            check("imem_wdata", imem_wdata, w);
            got = imem_wdata;
            for (int i = 0; i < ack_delay; i++) begin
                @(negedge clk);
                check("we held", 32'(imem_we), 32'd1);
                check("addr held", 32'(imem_addr), 32'(exp_addr));
                check("wdata held", imem_wdata, w);
                check("in_ready while writing", 32'(in_ready), 32'd0);
            end
            imem_ack = 1'b1;
            @(negedge clk);
            imem_ack = 1'b0;
            exp_count++;
            exp_addr = (exp_addr + 1) % (1 << ADDR_W);
            exp_full = (exp_count == DEPTH);
            check("we after ack", 32'(imem_we), 32'd0);
        end else begin
            repeat (3) begin @(negedge clk); if (imem_we) saw_we = 1'b1; end
            check("no write on illegal", 32'(saw_we), 32'd0);
            exp_err = 1'b1;
        end
        check("word_count", 32'(word_count), 32'(exp_count));
        check("imem_addr after", 32'(imem_addr), 32'(exp_addr));
        check("full", 32'(full), 32'(exp_full));
        check("err", 32'(err), 32'(exp_err));
        check("in_ready after", 32'(in_ready), 32'(!exp_full));
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        exp_count = 0; exp_addr = BASE_ADDR; exp_err = 1'b0; exp_full = 1'b0;
        check("restart addr", 32'(imem_addr), 32'(BASE_ADDR));
        check("restart count", 32'(word_count), 32'd0);
        check("restart err", 32'(err), 32'd0);
        check("restart full", 32'(full), 32'd0);
        check("restart in_ready", 32'(in_ready), 32'd1);
    endtask

    function automatic bun_t rand_bun();
        bun_t b = blank();
        int kind = int'($urandom_range(0, 3));
        b.cond = 4'($urandom); b.rn = 4'($urandom); b.rd = 4'($urandom);
        b.shift = 12'($urandom); b.imm24 = 24'($urandom); b.imm = 1'($urandom);
        case (kind)
            0: b.branch = 1'b1;
            1: begin
                b.alu = 4'd2;
                b.mem_read = 1'($urandom);
                b.mem_write = !b.mem_read;
                b.wb_en = b.mem_read;
            end
            2: begin
                b.alu = 4'($urandom); b.wb_en = 1'($urandom); b.status_en = 1'($urandom);
            end
            default: begin
                b.alu = 4'($urandom); b.wb_en = 1'($urandom); b.status_en = 1'($urandom);
                b.mem_read = 1'($urandom); b.mem_write = 1'($urandom); b.branch = 1'($urandom);
            end
        endcase
        return b;
    endfunction

    initial begin
        bun_t b;
        logic [31:0] got;
        int waited;

        rst = 1'b0; restart = 1'b0; in_valid = 1'b0; imem_ack = 1'b0;
        drive(blank());
        exp_count = 0; exp_addr = BASE_ADDR; exp_err = 1'b0; exp_full = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst in_ready", 32'(in_ready), 32'd0);
        check("rst imem_we", 32'(imem_we), 32'd0);
        check("rst imem_addr", 32'(imem_addr), 32'(BASE_ADDR));
        check("rst imem_wdata", imem_wdata, 32'd0);
        check("rst full", 32'(full), 32'd0);
        check("rst err", 32'(err), 32'd0);
        check("rst word_count", 32'(word_count), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("in_ready after reset", 32'(in_ready), 32'd1);

        // ADD R1,R2,R3
        b = blank(); b.alu = 4'b0010; b.wb_en = 1'b1; b.rn = 4'd2; b.rd = 4'd1; b.shift = 12'h003;
        send(b, 0, got);
        check("ADD R1,R2,R3", got, 32'hE0821003);

        // CMP R2,#5 with ack held off 3 cycles
        b = blank(); b.alu = 4'b0100; b.status_en = 1'b1; b.imm = 1'b1; b.rn = 4'd2; b.shift = 12'h005;
        send(b, 3, got);
        check("CMP R2,#5", got, 32'hE3520005);

        // mem_read and mem_write together: flagged, nothing written
        b = blank(); b.alu = 4'b0010; b.mem_read = 1'b1; b.mem_write = 1'b1; b.wb_en = 1'b1;
        send(b, 0, got);

        // LDR R0,[R1,#4] still written after the illegal bundle
        b = blank(); b.alu = 4'b0010; b.mem_read = 1'b1; b.wb_en = 1'b1; b.rn = 4'd1; b.shift = 12'h004;
        send(b, 1, got);
        check("LDR R0,[R1,#4]", got, 32'hE5910004);

        // B -2: fourth write fills the DEPTH=4 memory
        b = blank(); b.branch = 1'b1; b.imm24 = 24'hFFFFFE;
        send(b, 2, got);
        check("B imm24", got, 32'hEAFFFFFE);
        check("full after DEPTH writes", 32'(full), 32'd1);
        @(negedge clk);
        check("in_ready stays low when full", 32'(in_ready), 32'd0);
        do_restart();

        // Random bundles against the model
        for (int i = 0; i < 40; i++) begin
            if (exp_full) do_restart();
            send(rand_bun(), int'($urandom_range(0, 3)), got);
        end
        if (exp_full) do_restart();

        // Reset while a write is pending ack
        b = blank(); b.alu = 4'b0010; b.wb_en = 1'b1; b.rn = 4'd3; b.rd = 4'd4; b.shift = 12'h0AB;
        drive(b);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        waited = 0;
        while (!imem_we && waited < 6) begin @(negedge clk); waited++; end
        check("we before mid-write reset", 32'(imem_we), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("mid-write rst imem_we", 32'(imem_we), 32'd0);
        check("mid-write rst imem_addr", 32'(imem_addr), 32'(BASE_ADDR));
        check("mid-write rst imem_wdata", imem_wdata, 32'd0);
        check("mid-write rst word_count", 32'(word_count), 32'd0);
        check("mid-write rst err", 32'(err), 32'd0);
        check("mid-write rst full", 32'(full), 32'd0);
        check("mid-write rst in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        exp_count = 0; exp_addr = BASE_ADDR; exp_err = 1'b0; exp_full = 1'b0;
        @(negedge clk);
        check("in_ready after mid-write reset", 32'(in_ready), 32'd1);
        send(b, 0, got);
        check("first word after reset", got, 32'hE08340AB);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
